// File: rtl/c_pkt_gnt_hold.sv
// Packet grant hold: keeps an arbiter's grant locked to one port from head flit to tail flit,
// with an optional watchdog that forcibly releases a lock held too long.
module c_pkt_gnt_hold #(
  parameter int unsigned num_ports = 4,
  parameter int unsigned max_hold  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic [0:num_ports-1] req,
  input  logic [0:num_ports-1] tail,
  input  logic                 xfer_ready,
  output logic [0:num_ports-1] arb_req,
  input  logic [0:num_ports-1] arb_gnt,
  output logic                 arb_update,
  output logic [0:num_ports-1] gnt,
  output logic                 locked,
  output logic                 timeout
);

  localparam int unsigned CntW = (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'((max_hold == 0) ? 0 : max_hold - 1);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e               state_q;
  logic [0:num_ports-1] owner_q;
  logic [CntW-1:0]      hold_cnt_q, hold_cnt_d;
  logic                 timeout_q;
  logic                 tail_xfer;
  logic                 expire;

  always_comb begin
    arb_req    = '0;
    arb_update = 1'b0;
    gnt        = '0;
    if (state_q == StIdle) begin
      arb_req    = req & {num_ports{xfer_ready}};
      gnt        = arb_gnt;
      arb_update = |arb_gnt;
    end else begin
      gnt = owner_q & req & {num_ports{xfer_ready}};
    end
  end

  assign tail_xfer  = |(gnt & tail);
  assign expire     = (max_hold != 0) && (hold_cnt_q == HoldLast);
  // Saturating so an unlimited hold never wraps.
  assign hold_cnt_d = (hold_cnt_q == {CntW{1'b1}}) ? hold_cnt_q : hold_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (active) begin
      unique case (state_q)
        StIdle: begin
          if ((|arb_gnt) && !tail_xfer) begin
            state_q    <= StLocked;
            owner_q    <= arb_gnt;
            hold_cnt_q <= '0;
          end
        end
        StLocked: begin
          hold_cnt_q <= hold_cnt_d;
          // A tail on the expiry cycle is a normal release, not a timeout.
          if (tail_xfer) begin
            state_q <= StIdle;
            owner_q <= '0;
          end else if (expire) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign locked  = (state_q == StLocked);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_c_pkt_gnt_hold.sv
// Randomized bench for c_pkt_gnt_hold against a packet-level reference model, plus
// directed single-flit and watchdog scenarios.
module tb_c_pkt_gnt_hold;

  localparam int unsigned N  = 4;
  localparam int unsigned MH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         active;
  logic [0:N-1] req, tail, arb_gnt;
  logic         xfer_ready;
  logic [0:N-1] arb_req, gnt;
  logic         arb_update, locked, timeout;

  c_pkt_gnt_hold #(.num_ports(N), .max_hold(MH)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .req        (req),
    .tail       (tail),
    .xfer_ready (xfer_ready),
    .arb_req    (arb_req),
    .arb_gnt    (arb_gnt),
    .arb_update (arb_update),
    .gnt        (gnt),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner port index (-1 = no packet in flight), locked cycles spent.
  int m_owner = -1;
  int m_held  = 0;
  bit m_tmo   = 1'b0;
  int rr      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic act, input logic [0:N-1] rq,
                       input logic [0:N-1] tl, input logic xr);
    logic [0:N-1] e_areq, e_gnt;
    logic         e_upd;
    int           g;
    @(negedge clk);
    reset = r; active = act; req = rq; tail = tl; xfer_ready = xr;
    if (!r) begin
      m_owner = -1; m_held = 0; m_tmo = 1'b0;
    end
    e_areq = '0; e_gnt = '0; e_upd = 1'b0; g = -1;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) e_areq[i] = rq[i] & xr;
      // Round-robin arbiter stub answering the expected request vector.
      for (int k = 0; k < N; k++) begin
        if (g < 0 && e_areq[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    arb_gnt = '0;
    if (g >= 0) arb_gnt[g] = 1'b1;
    if (m_owner < 0) begin
      e_gnt = arb_gnt;
      e_upd = (g >= 0);
    end else if (rq[m_owner] && xr) begin
      e_gnt[m_owner] = 1'b1;
    end
    #1;
    check("arb_req", 32'(arb_req), 32'(e_areq));
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("arb_update", 32'(arb_update), 32'(e_upd));
    check("locked", 32'(locked), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_tmo));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    // Advance the model to the state after the coming rising edge.
    if (r && act) begin
      if (m_owner < 0) begin
        if (g >= 0) begin
          rr = (g + 1) % N;
          if (!tl[g]) begin
            m_owner = g;
            m_held  = 0;
          end
        end
      end else begin
        m_held++;
        if (rq[m_owner] && xr && tl[m_owner]) begin
          m_owner = -1;
        end else if (m_held == MH) begin
          m_owner = -1;
          m_tmo   = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [0:N-1] rq, tl;
    logic         r, act, xr;
    reset = 1'b0; active = 1'b1; req = '0; tail = '0; xfer_ready = 1'b1; arb_gnt = '0;

    // Reset state with live combinational outputs.
    cycle(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1);
    cycle(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);

    // Single-flit packet on port 1 stays unlocked.
    cycle(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b1);
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);

    // Watchdog: head on port 0, then 8 locked cycles without a tail.
    cycle(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1);
    for (int i = 0; i < MH; i++) cycle(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    check("wd_locked_drop", 32'(locked), 32'd0);
    check("wd_tmo_set", 32'(timeout), 32'd1);

    // Tail exactly on the expiry cycle is a normal release.
    cycle(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1);
    for (int i = 0; i < MH - 1; i++) cycle(1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1);
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
    check("wd_tail_release", 32'(locked), 32'd0);
    check("wd_tmo_clear", 32'(timeout), 32'd0);

    // Randomized traffic with stalls, clock-enable gaps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(199) != 0);
      act = ($urandom_range(9) != 0);
      xr  = ($urandom_range(4) != 0);
      for (int p = 0; p < N; p++) begin
        rq[p] = ($urandom_range(3) != 0);
        tl[p] = ($urandom_range(4) == 0);
      end
      cycle(r, act, rq, tl, xr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
